stopwatch_counter: RTL

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_counter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// Minutes:seconds stopwatch with up/down counting, wrap or saturate at the terminal value, and a sticky overflow flag.
// Define STOPWATCH_LAP_EN to add the lap-capture ports and registers.
module stopwatch_counter #(
  parameter int unsigned SEC_W   = 6,
  parameter int unsigned MIN_W   = 6,
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59,
  parameter bit          WRAP    = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             run_i,
  input  logic             tick_i,
  input  logic             dir_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [SEC_W-1:0] load_sec_i,
  input  logic [MIN_W-1:0] load_min_i,
`ifdef STOPWATCH_LAP_EN
  input  logic             lap_i,
  output logic [SEC_W-1:0] lap_sec_o,
  output logic [MIN_W-1:0] lap_min_o,
  output logic             lap_valid_o,
`endif
  output logic [SEC_W-1:0] seconds_o,
  output logic [MIN_W-1:0] minutes_o,
  output logic             terminal_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [SEC_W-1:0] SMAX = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] MMAX = MIN_W'(MIN_MAX);

  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic             at_max, at_zero, sat;

  assign at_max  = (sec_q == SMAX) && (min_q == MMAX);
  assign at_zero = (sec_q == '0) && (min_q == '0);

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    ovf_d   = ovf_q;
    state_d = state_q;
    sat     = 1'b0;
    if (clr_i) begin
      sec_d   = '0;
      min_d   = '0;
      ovf_d   = 1'b0;
      state_d = IDLE;
    end else if (load_i) begin
      sec_d   = (load_sec_i > SMAX) ? SMAX : load_sec_i;
      min_d   = (load_min_i > MMAX) ? MMAX : load_min_i;
      ovf_d   = 1'b0;
      state_d = IDLE;
    end else begin
      if (state_q == COUNT && tick_i) begin
        if (!dir_i) begin
          if (sec_q < SMAX) begin
            sec_d = sec_q + SEC_W'(1);
          end else if (min_q < MMAX) begin
            sec_d = '0;
            min_d = min_q + MIN_W'(1);
          end else begin
            ovf_d = 1'b1;
            if (WRAP) begin
              sec_d = '0;
              min_d = '0;
            end else begin
              sat = 1'b1;
            end
          end
        end else begin
          if (sec_q > '0) begin
            sec_d = sec_q - SEC_W'(1);
          end else if (min_q > '0) begin
            sec_d = SMAX;
            min_d = min_q - MIN_W'(1);
          end else begin
            ovf_d = 1'b1;
            if (WRAP) begin
              sec_d = SMAX;
              min_d = MMAX;
            end else begin
              sat = 1'b1;
            end
          end
        end
      end
      // A step taken on the same edge as run falling still counts; saturation beats the run check.
      case (state_q)
        IDLE:    if (run_i) state_d = COUNT;
        COUNT:   if (sat) state_d = DONE; else if (!run_i) state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sec_q   <= '0;
      min_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign seconds_o  = sec_q;
  assign minutes_o  = min_q;
  assign ovf_o      = ovf_q;
  assign state_o    = state_q;
  assign terminal_o = dir_i ? at_zero : at_max;

`ifdef STOPWATCH_LAP_EN
  logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
  logic [MIN_W-1:0] lap_min_q, lap_min_d;
  logic             lap_valid_q, lap_valid_d;

  // Captures the pre-update count, so a lap on a step edge records the old value.
  always_comb begin
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_valid_d = 1'b0;
    if (clr_i) begin
      lap_sec_d = '0;
      lap_min_d = '0;
    end else if (lap_i) begin
      lap_sec_d   = sec_q;
      lap_min_d   = min_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_sec_o   = lap_sec_q;
  assign lap_min_o   = lap_min_q;
  assign lap_valid_o = lap_valid_q;
`endif

endmodule
